btn_cond_multi: RTL and testbench
=================================

# btn_cond_multi

Multi-channel button conditioner and the parametrised successor to the single-button debounce/edge front end. Each of `N_CH` raw board inputs is synchronised, debounced with a saturating counter and edge-detected. Each channel's edge output is selected at run time: rising, falling, both or none. An optional hold/auto-repeat generator is compiled in by macro. The block sits between the board pins and the CPU/IO-bus input registers, and replaces per-button instances with one block.

## Interface

- `N_CH`, 5: number of button channels (≥1).
- `DEB_CYCLES`, 1_000_000: consecutive stable cycles required to accept a new level (≥1; 10 ms @ 100 MHz).
- `HOLD_CYCLES`, 50_000_000: cycles of accepted-high before the first hold pulse (≥1).
- `REPEAT_CYCLES`, 10_000_000: cycles between subsequent hold pulses (≥1).

- `clk` in 1: single clock. All logic is on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `btn_in` in `N_CH`: raw, asynchronous button levels.
- `mode` in `2*N_CH`: per-channel edge select, with `mode[2i+1:2i]` for channel i.
  - 00 = none
  - 01 = rising
  - 10 = falling
  - 11 = both
- `btn_level` out `N_CH`: debounced level.
- `btn_edge` out `N_CH`: one-cycle pulse on an accepted transition matching `mode`.
- `btn_hold` out `N_CH`: one-cycle hold/repeat pulse. Constant 0 when the feature is compiled out.

## Operation

- Per channel:
  - Two-flop synchroniser `s1 → s2`, reset 0.
  - Debounce counter, width `$clog2(DEB_CYCLES+1)`.
  - Stable register, which drives `btn_level`.
- Debounce rule:
  - In any cycle with `s2 == stable`, the counter clears to 0.
  - In any cycle with `s2 != stable`, the counter increments.
  - When the increment would reach `DEB_CYCLES`: `stable` toggles and the counter clears. The counter never wraps.
  - A glitch shorter than `DEB_CYCLES` cycles restarts the count and is never accepted.
- Edge rule: on the cycle `stable` toggles, register `btn_edge[i]` = 1 when either condition holds:
  - new level 1 and `mode[2i]` = 1;
  - new level 0 and `mode[2i+1]` = 1.
- `mode` is sampled live, with no latching. A mode change affects only transitions accepted on or after that cycle.
- Channels are fully independent. Simultaneous transitions on several channels give simultaneous pulses.
- Reset values, all 0:
  - outputs `btn_level`, `btn_edge`, `btn_hold`;
  - all internal registers (synchronisers, counters, stable, hold state).
- Reset mid-debounce discards the partial count.
- A button held through reset release is accepted as high `2+DEB_CYCLES` cycles later and produces a rising edge if the mode allows.

## Timing

- Raw change sampled at clock edge k; `s2` reflects it at edge k+2.
- `btn_level` and `btn_edge` update together at edge k+1+DEB_CYCLES+1, i.e. latency `DEB_CYCLES+2` cycles.
- `btn_edge` is high for exactly one cycle per accepted transition.
- `DEB_CYCLES = 1`: a change held for one `s2` sample is accepted on the next edge.
- Hold timing:
  - The first `btn_hold` pulse occurs `HOLD_CYCLES` cycles after `btn_level` rises.
  - Subsequent pulses follow every `REPEAT_CYCLES` cycles while `btn_level` = 1.

## Configuration

- Macro: `BTN_COND_HOLD_EN`.
- Defined: per-channel hold FSM with states `IDLE`, `WAIT_HOLD`, `REPEAT`, and a counter sized `$clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1)`.
  - `IDLE → WAIT_HOLD` on `stable` rising. Counter cleared.
  - `WAIT_HOLD → REPEAT` when the count reaches `HOLD_CYCLES-1`. Pulse `btn_hold`, clear the counter.
  - In `REPEAT`, pulse `btn_hold` when the count reaches `REPEAT_CYCLES-1`, then clear the counter.
  - Any state returns to `IDLE` on `stable` = 0. This takes priority over a same-cycle pulse, so no pulse is emitted on the release cycle.
  - `btn_hold` is independent of `mode`.
- Undefined: no hold logic is generated and `btn_hold` is tied to 0.

## Structure

- Shared package `btn_cond_pkg`:
  - edge-mode constants `EDGE_NONE`, `EDGE_RISE`, `EDGE_FALL`, `EDGE_BOTH` (2-bit);
  - hold FSM state typedef `hold_state_t`.
- One natural sub-module, `btn_cond_chan`. It holds the synchroniser, debounce, edge and optional hold logic for one channel.
- The top level is a generate loop over `N_CH` instances plus `mode` slicing.

## Test plan

All scenarios use `DEB_CYCLES=4`, `HOLD_CYCLES=20`, `REPEAT_CYCLES=8`, `N_CH=2`.

- Reset: hold `rstn`=0 with `btn_in`=2'b11, then release.
  - All outputs are 0 while `rstn`=0.
  - `btn_level` = 11 at cycle 6 after release.
  - `btn_edge` = 11 for one cycle with mode = BOTH.
- Glitch rejection: ch0 pulses high for 3 cycles, then returns low.
  - `btn_level[0]` stays 0.
  - `btn_edge[0]` is never asserted.
- Mode select: ch0 mode = RISE, ch1 mode = FALL; press and release both.
  - `btn_edge[0]` pulses only on press.
  - `btn_edge[1]` pulses only on release.
  - Each pulse is exactly 1 cycle.
- Bounce: ch0 toggles every 2 cycles for 12 cycles, then holds high.
  - Exactly one rising edge.
  - It occurs 6 cycles after the final raw transition.
- Hold (`BTN_COND_HOLD_EN`): hold ch0 high 60 cycles after acceptance.
  - `btn_hold[0]` pulses at +20, +28, +36, +44, +52.
  - No pulse after release.
  - Without the macro, `btn_hold` stays 0.
- Reset mid-debounce: assert `rstn`=0 two cycles into a 4-cycle count.
  - After release the count restarts from 0.
  - Acceptance occurs 6 cycles after reset release.

Source files
------------

// File: rtl/btn_cond_pkg.sv
// ============================================================================
// Module      : btn_cond_pkg
// Description : Shared definitions for the multi-channel button conditioner:
//               2-bit edge-mode encodings, the hold/auto-repeat FSM state
//               type and a small elaboration-time helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package btn_cond_pkg;

    // Per-channel edge select. Bit 0 enables rising, bit 1 enables falling.
    localparam logic [1:0] EDGE_NONE = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HOLD = 2'd1,
        REPEAT    = 2'd2
    } hold_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_cond_multi_if.sv
// ============================================================================
// Module      : btn_cond_multi_if
// Description : Signal bundle between the board-side button inputs / mode
//               register and the conditioned outputs seen by the IO bus.
// Ports       : btn_in    - raw asynchronous button levels   (N_CH)
//               mode      - per-channel edge select          (2*N_CH)
//               btn_level - debounced levels                 (N_CH)
//               btn_edge  - one-cycle accepted-edge pulses   (N_CH)
//               btn_hold  - one-cycle hold/repeat pulses     (N_CH)
//               master modport drives btn_in/mode; slave is the conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface btn_cond_multi_if #(
    parameter int N_CH = 5
);
    logic [N_CH-1:0]   btn_in;
    logic [2*N_CH-1:0] mode;
    logic [N_CH-1:0]   btn_level;
    logic [N_CH-1:0]   btn_edge;
    logic [N_CH-1:0]   btn_hold;

    modport master (
        output btn_in,
        output mode,
        input  btn_level,
        input  btn_edge,
        input  btn_hold
    );

    modport slave (
        input  btn_in,
        input  mode,
        output btn_level,
        output btn_edge,
        output btn_hold
    );
endinterface

`default_nettype wire

// File: rtl/btn_cond_chan.sv
// ============================================================================
// Module      : btn_cond_chan
// Description : One button channel: two-flop synchroniser, saturating
//               debounce counter, mode-selected edge pulse and, when the
//               macro BTN_COND_HOLD_EN is defined, a hold/auto-repeat
//               generator. Without the macro btn_hold is tied to 0.
// Ports       : clk       - clock, rising edge
//               rstn      - asynchronous active-low reset
//               btn_in    - raw button level
//               mode      - edge select (bit0 rising, bit1 falling)
//               btn_level - debounced level
//               btn_edge  - one-cycle pulse on an accepted, enabled edge
//               btn_hold  - one-cycle hold/repeat pulse
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_cond_chan
    import btn_cond_pkg::*;
#(
    parameter int DEB_CYCLES    = 1_000_000,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       btn_in,
    input  logic [1:0] mode,
    output logic       btn_level,
    output logic       btn_edge,
    output logic       btn_hold
);

    localparam int             DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic [DEB_W-1:0] r_cnt;
    logic             r_edge;
    logic             w_accept;

    // The count only advances while s2 disagrees with the accepted level,
    // so any agreeing sample restarts it; it can never pass DEB_LAST.
    assign w_accept = (r_s2 != r_stable) && (r_cnt == DEB_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_edge   <= 1'b0;
        end else begin
            r_s1   <= btn_in;
            r_s2   <= r_s1;
            r_edge <= 1'b0;
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= ~r_stable;
                r_cnt    <= '0;
                // New level is ~r_stable: currently low means a rising edge.
                r_edge   <= |(mode & (r_stable ? EDGE_FALL : EDGE_RISE));
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign btn_level = r_stable;
    assign btn_edge  = r_edge;

`ifdef BTN_COND_HOLD_EN
    localparam int              HOLD_W    = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES) + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

    hold_state_t       r_state;
    hold_state_t       w_state_next;
    logic [HOLD_W-1:0] r_hcnt;
    logic [HOLD_W-1:0] w_hcnt_next;
    logic              r_hold;
    logic              w_hold_next;
    logic              w_stable_next;

    // Looking at the level stable is about to take lets the FSM leave IDLE
    // on the same edge the level rises, so the first pulse lands exactly
    // HOLD_CYCLES after btn_level goes high, and lets a release suppress a
    // pulse falling due on that same edge.
    assign w_stable_next = r_stable ^ w_accept;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_hcnt  <= '0;
            r_hold  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_hcnt  <= w_hcnt_next;
            r_hold  <= w_hold_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_hcnt_next  = r_hcnt + 1'b1;
        w_hold_next  = 1'b0;
        if (!w_stable_next) begin
            w_state_next = IDLE;
            w_hcnt_next  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_next = WAIT_HOLD;
                    w_hcnt_next  = '0;
                end
                WAIT_HOLD: begin
                    if (r_hcnt == HOLD_LAST) begin
                        w_state_next = REPEAT;
                        w_hcnt_next  = '0;
                        w_hold_next  = 1'b1;
                    end
                end
                REPEAT: begin
                    if (r_hcnt == REP_LAST) begin
                        w_hcnt_next = '0;
                        w_hold_next = 1'b1;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_hcnt_next  = '0;
                end
            endcase
        end
    end

    assign btn_hold = r_hold;
`else
    assign btn_hold = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/btn_cond_multi.sv
// ============================================================================
// Module      : btn_cond_multi
// Description : N_CH-channel button conditioner. Each channel is synchronised,
//               debounced and edge-detected independently; the per-channel
//               2-bit mode field selects which edges pulse btn_edge. The
//               hold/auto-repeat generator is present only when the macro
//               BTN_COND_HOLD_EN is defined; otherwise btn_hold is 0.
// Ports       : clk  - clock, rising edge
//               rstn - asynchronous active-low reset
//               bus  - btn_cond_multi_if.slave (btn_in, mode, btn_level,
//                      btn_edge, btn_hold)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_cond_multi
    import btn_cond_pkg::*;
#(
    parameter int N_CH          = 5,
    parameter int DEB_CYCLES    = 1_000_000,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic                  clk,
    input  logic                  rstn,
    btn_cond_multi_if.slave       bus
);

    logic [N_CH-1:0] w_level;
    logic [N_CH-1:0] w_edge;
    logic [N_CH-1:0] w_hold;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        btn_cond_chan #(
            .DEB_CYCLES    (DEB_CYCLES),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_chan (
            .clk       (clk),
            .rstn      (rstn),
            .btn_in    (bus.btn_in[i]),
            .mode      (bus.mode[2*i +: 2]),
            .btn_level (w_level[i]),
            .btn_edge  (w_edge[i]),
            .btn_hold  (w_hold[i])
        );
    end

    assign bus.btn_level = w_level;
    assign bus.btn_edge  = w_edge;
    assign bus.btn_hold  = w_hold;

endmodule

`default_nettype wire

// File: tb/tb_btn_cond_multi.sv
// ============================================================================
// Module      : tb_btn_cond_multi
// Description : Directed self-checking bench for btn_cond_multi with
//               N_CH=2, DEB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8.
//               Hold expectations follow the macro BTN_COND_HOLD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_cond_multi;

    logic clk;
    logic rstn;
    int   total;
    int   bad;

    btn_cond_multi_if #(.N_CH(2)) bus ();

    btn_cond_multi #(
        .N_CH          (2),
        .DEB_CYCLES    (4),
        .HOLD_CYCLES   (20),
        .REPEAT_CYCLES (8)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [1:0] exp_level;
        logic [1:0] exp_edge;
        rstn        = 1'b0;
        bus.btn_in  = 2'b11;
        bus.mode    = 4'b1111;
        for (int t = 1; t <= 3; t++) begin
            tick();
            total++;
            if ({bus.btn_level, bus.btn_edge, bus.btn_hold} !== 6'b0) begin
                bad++;
                $display("FAIL reset_hold t=%0d got lvl=%b edg=%b hld=%b want all 0",
                         t, bus.btn_level, bus.btn_edge, bus.btn_hold);
            end
        end
        rstn = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            exp_level = (t >= 6) ? 2'b11 : 2'b00;
            exp_edge  = (t == 6) ? 2'b11 : 2'b00;
            total++;
            if (bus.btn_level !== exp_level || bus.btn_edge !== exp_edge) begin
                bad++;
                $display("FAIL reset_release t=%0d got lvl=%b edg=%b want lvl=%b edg=%b",
                         t, bus.btn_level, bus.btn_edge, exp_level, exp_edge);
            end
        end
        bus.btn_in = 2'b00;
        for (int t = 1; t <= 7; t++) begin
            tick();
            exp_level = (t >= 6) ? 2'b00 : 2'b11;
            exp_edge  = (t == 6) ? 2'b11 : 2'b00;
            total++;
            if (bus.btn_level !== exp_level || bus.btn_edge !== exp_edge) begin
                bad++;
                $display("FAIL reset_fall t=%0d got lvl=%b edg=%b want lvl=%b edg=%b",
                         t, bus.btn_level, bus.btn_edge, exp_level, exp_edge);
            end
        end
    endtask

    task automatic test_glitch();
        bus.mode = 4'b1111;
        for (int t = 0; t < 14; t++) begin
            if (t == 0) bus.btn_in = 2'b01;
            if (t == 3) bus.btn_in = 2'b00;
            tick();
            total++;
            if (bus.btn_level[0] !== 1'b0 || bus.btn_edge[0] !== 1'b0) begin
                bad++;
                $display("FAIL glitch t=%0d got lvl0=%b edg0=%b want 0 0",
                         t, bus.btn_level[0], bus.btn_edge[0]);
            end
        end
    endtask

    task automatic test_mode();
        logic [1:0] exp_level;
        logic [1:0] exp_edge;
        // ch1 falling only, ch0 rising only
        bus.mode   = 4'b1001;
        bus.btn_in = 2'b11;
        for (int t = 1; t <= 7; t++) begin
            tick();
            exp_level = (t >= 6) ? 2'b11 : 2'b00;
            exp_edge  = (t == 6) ? 2'b01 : 2'b00;
            total++;
            if (bus.btn_level !== exp_level || bus.btn_edge !== exp_edge) begin
                bad++;
                $display("FAIL mode_press t=%0d got lvl=%b edg=%b want lvl=%b edg=%b",
                         t, bus.btn_level, bus.btn_edge, exp_level, exp_edge);
            end
        end
        bus.btn_in = 2'b00;
        for (int t = 1; t <= 7; t++) begin
            tick();
            exp_level = (t >= 6) ? 2'b00 : 2'b11;
            exp_edge  = (t == 6) ? 2'b10 : 2'b00;
            total++;
            if (bus.btn_level !== exp_level || bus.btn_edge !== exp_edge) begin
                bad++;
                $display("FAIL mode_release t=%0d got lvl=%b edg=%b want lvl=%b edg=%b",
                         t, bus.btn_level, bus.btn_edge, exp_level, exp_edge);
            end
        end
    endtask

    task automatic test_bounce();
        logic exp_edge;
        logic exp_level;
        bus.mode = 4'b0011;
        for (int seg = 0; seg < 6; seg++) begin
            bus.btn_in = (seg % 2 == 0) ? 2'b01 : 2'b00;
            for (int k = 0; k < 2; k++) begin
                tick();
                total++;
                if (bus.btn_level[0] !== 1'b0 || bus.btn_edge[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL bounce_chatter seg=%0d got lvl0=%b edg0=%b want 0 0",
                             seg, bus.btn_level[0], bus.btn_edge[0]);
                end
            end
        end
        bus.btn_in = 2'b01;
        for (int t = 1; t <= 10; t++) begin
            tick();
            exp_edge  = (t == 6);
            exp_level = (t >= 6);
            total++;
            if (bus.btn_edge[0] !== exp_edge || bus.btn_level[0] !== exp_level) begin
                bad++;
                $display("FAIL bounce_settle t=%0d got lvl0=%b edg0=%b want lvl0=%b edg0=%b",
                         t, bus.btn_level[0], bus.btn_edge[0], exp_level, exp_edge);
            end
        end
        bus.btn_in = 2'b00;
        repeat (8) tick();
        total++;
        if (bus.btn_level !== 2'b00) begin
            bad++;
            $display("FAIL bounce_release got lvl=%b want 00", bus.btn_level);
        end
    endtask

    task automatic test_hold();
        logic exp_hold;
        logic exp_level;
        bus.mode   = 4'b0000;
        bus.btn_in = 2'b01;
        repeat (6) tick();
        total++;
        if (bus.btn_level !== 2'b01 || bus.btn_edge !== 2'b00) begin
            bad++;
            $display("FAIL hold_accept got lvl=%b edg=%b want lvl=01 edg=00",
                     bus.btn_level, bus.btn_edge);
        end
        for (int t = 1; t <= 80; t++) begin
            tick();
`ifdef BTN_COND_HOLD_EN
            exp_hold = (t == 20) || (t == 28) || (t == 36) || (t == 44) || (t == 52);
`else
            exp_hold = 1'b0;
`endif
            exp_level = (t < 60);
            total++;
            if (bus.btn_hold !== {1'b0, exp_hold} || bus.btn_level[0] !== exp_level) begin
                bad++;
                $display("FAIL hold_pulse t=%0d got hld=%b lvl0=%b want hld=%b lvl0=%b",
                         t, bus.btn_hold, bus.btn_level[0], {1'b0, exp_hold}, exp_level);
            end
            // Release so the level falls on the edge a repeat pulse would be due.
            if (t == 54) bus.btn_in = 2'b00;
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] exp_level;
        logic [1:0] exp_edge;
        bus.mode   = 4'b1111;
        bus.btn_in = 2'b10;
        repeat (4) tick();
        rstn = 1'b0;
        #1;
        total++;
        if (bus.btn_level !== 2'b00 || bus.btn_edge !== 2'b00) begin
            bad++;
            $display("FAIL midreset_assert got lvl=%b edg=%b want 00 00",
                     bus.btn_level, bus.btn_edge);
        end
        repeat (2) tick();
        rstn = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            exp_level = (t >= 6) ? 2'b10 : 2'b00;
            exp_edge  = (t == 6) ? 2'b10 : 2'b00;
            total++;
            if (bus.btn_level !== exp_level || bus.btn_edge !== exp_edge) begin
                bad++;
                $display("FAIL midreset_restart t=%0d got lvl=%b edg=%b want lvl=%b edg=%b",
                         t, bus.btn_level, bus.btn_edge, exp_level, exp_edge);
            end
        end
        bus.btn_in = 2'b00;
        repeat (8) tick();
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rstn       = 1'b0;
        bus.btn_in = 2'b00;
        bus.mode   = 4'b0000;
        #2;
        test_reset();
        test_glitch();
        test_mode();
        test_bounce();
        test_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
